// File: rtl/chirp_sweep_generator.sv
// Linear-FM chirp phase generator: emits one phase word per clock while a chirp runs.
// Optional post-chirp guard interval is built when CHIRP_GUARD_EN is defined.
module chirp_sweep_generator #(
  parameter int PHASE_W        = 32,
  parameter int LEN_W          = 32,
  parameter int STARTUP_CYCLES = 16,
  parameter int GUARD_CYCLES   = 8
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               chirp_init,
  input  logic               chirp_enable,
  input  logic [LEN_W-1:0]   chirp_len,
  input  logic [PHASE_W-1:0] chirp_freq_offset,
  input  logic [PHASE_W-1:0] chirp_tuning_word,
  output logic               chirp_ready,
  output logic               chirp_active,
  output logic               chirp_done,
  output logic [PHASE_W-1:0] phase_out,
  output logic               phase_valid,
  output logic [2:0]         state_dbg
);

  // Handshake: a start is taken on any edge where chirp_ready, chirp_init and
  // chirp_enable are all high and chirp_len is non-zero; chirp_enable must stay
  // high for every sample, otherwise the chirp is dropped without chirp_done.
  typedef enum logic [2:0] {
    S_STARTUP = 3'd0,
    S_IDLE    = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_GUARD   = 3'd4
  } state_t;

  state_t             state;
  logic [PHASE_W-1:0] phase_acc;
  logic [PHASE_W-1:0] freq_acc;
  logic [PHASE_W-1:0] rate;
  logic [LEN_W-1:0]   remaining;
  logic [31:0]        wait_cnt;
  logic [31:0]        wait_last;
  logic [PHASE_W-1:0] phase_next;

  // STARTUP and GUARD share one wait counter; only the terminal count differs.
  assign wait_last  = (state == S_GUARD) ? 32'(GUARD_CYCLES - 1) : 32'(STARTUP_CYCLES - 1);
  assign phase_next = phase_acc + freq_acc;
  assign state_dbg  = state;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= S_STARTUP;
      chirp_ready  <= 1'b0;
      chirp_active <= 1'b0;
      chirp_done   <= 1'b0;
      phase_valid  <= 1'b0;
      phase_out    <= '0;
      phase_acc    <= '0;
      freq_acc     <= '0;
      rate         <= '0;
      remaining    <= '0;
      wait_cnt     <= '0;
    end else begin
      case (state)
        S_STARTUP, S_GUARD: begin
          if (wait_cnt == wait_last) begin
            state       <= S_IDLE;
            chirp_ready <= 1'b1;
            wait_cnt    <= '0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_IDLE: begin
          if (chirp_init && chirp_enable && (chirp_len != '0)) begin
            state        <= S_RUN;
            chirp_ready  <= 1'b0;
            chirp_active <= 1'b1;
            phase_valid  <= 1'b1;
            phase_out    <= '0;
            phase_acc    <= '0;
            freq_acc     <= chirp_freq_offset;
            rate         <= chirp_tuning_word;
            remaining    <= chirp_len;
          end
        end
        S_RUN: begin
          if (!chirp_enable) begin
            state        <= S_IDLE;
            chirp_ready  <= 1'b1;
            chirp_active <= 1'b0;
            phase_valid  <= 1'b0;
          end else if (remaining == LEN_W'(1)) begin
            // Last sample is on display now; phase_out keeps it after the chirp.
            state        <= S_DONE;
            chirp_active <= 1'b0;
            phase_valid  <= 1'b0;
            chirp_done   <= 1'b1;
            remaining    <= remaining - LEN_W'(1);
          end else begin
            phase_acc <= phase_next;
            phase_out <= phase_next;
            freq_acc  <= freq_acc + rate;
            remaining <= remaining - LEN_W'(1);
          end
        end
        S_DONE: begin
          chirp_done <= 1'b0;
`ifdef CHIRP_GUARD_EN
          state    <= S_GUARD;
          wait_cnt <= '0;
`else
          state       <= S_IDLE;
          chirp_ready <= 1'b1;
`endif
        end
        default: begin
          state        <= S_STARTUP;
          chirp_ready  <= 1'b0;
          chirp_active <= 1'b0;
          chirp_done   <= 1'b0;
          phase_valid  <= 1'b0;
          wait_cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chirp_sweep_generator.sv
// Directed bench for chirp_sweep_generator: startup, sample values, wrap, abort,
// ignored starts, guard interval (when CHIRP_GUARD_EN is defined) and async reset.
module tb_chirp_sweep_generator;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        chirp_init = 1'b0;
  logic        chirp_enable = 1'b0;
  logic [31:0] chirp_len = '0;
  logic [31:0] chirp_freq_offset = '0;
  logic [31:0] chirp_tuning_word = '0;
  logic        chirp_ready;
  logic        chirp_active;
  logic        chirp_done;
  logic [31:0] phase_out;
  logic        phase_valid;
  logic [2:0]  state_dbg;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  chirp_sweep_generator dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .chirp_init        (chirp_init),
    .chirp_enable      (chirp_enable),
    .chirp_len         (chirp_len),
    .chirp_freq_offset (chirp_freq_offset),
    .chirp_tuning_word (chirp_tuning_word),
    .chirp_ready       (chirp_ready),
    .chirp_active      (chirp_active),
    .chirp_done        (chirp_done),
    .phase_out         (phase_out),
    .phase_valid       (phase_valid),
    .state_dbg         (state_dbg)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic start_chirp(input logic [31:0] off, input logic [31:0] tun, input logic [31:0] len);
    chirp_freq_offset = off;
    chirp_tuning_word = tun;
    chirp_len         = len;
    chirp_init        = 1'b1;
    @(negedge aclk);
    chirp_init = 1'b0;
  endtask

  // Drains valid samples against exp_q, then checks the done pulse and the
  // return to ready. init_at >= 0 fires a stray start at that sample index.
  task automatic run_and_check(input string tag, input int exp_n, input int init_at);
    int got = 0;
    while (phase_valid === 1'b1 && got < 64) begin
      if (got == 0) begin
        check({tag, "_active"}, 32'(chirp_active), 32'd1);
        check({tag, "_ready_busy"}, 32'(chirp_ready), 32'd0);
      end
      if (exp_q.size() > 0) check({tag, "_phase"}, phase_out, exp_q.pop_front());
      if (got == init_at) begin
        chirp_init        = 1'b1;
        chirp_freq_offset = 32'd999;
        chirp_len         = 32'd7;
      end else begin
        chirp_init = 1'b0;
      end
      got++;
      @(negedge aclk);
    end
    chirp_init = 1'b0;
    check({tag, "_count"}, 32'(got), 32'(exp_n));
    check({tag, "_done"}, 32'(chirp_done), 32'd1);
    check({tag, "_active_off"}, 32'(chirp_active), 32'd0);
`ifdef CHIRP_GUARD_EN
    for (int i = 0; i < 8; i++) begin
      chirp_init = 1'b1;
      @(negedge aclk);
      check({tag, "_guard_ready"}, 32'(chirp_ready), 32'd0);
      check({tag, "_guard_valid"}, 32'(phase_valid), 32'd0);
      check({tag, "_guard_done"}, 32'(chirp_done), 32'd0);
    end
    @(negedge aclk);
    chirp_init = 1'b0;
`else
    @(negedge aclk);
`endif
    check({tag, "_done_off"}, 32'(chirp_done), 32'd0);
    check({tag, "_ready_back"}, 32'(chirp_ready), 32'd1);
    check({tag, "_valid_off"}, 32'(phase_valid), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    chirp_init   = 1'b1;
    chirp_enable = 1'b1;
    chirp_len    = 32'd4;
    repeat (3) @(negedge aclk);
    check("rst_ready", 32'(chirp_ready), 32'd0);
    check("rst_valid", 32'(phase_valid), 32'd0);
    check("rst_phase", phase_out, 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_done", 32'(chirp_done), 32'd0);
    aresetn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge aclk);
      check("startup_ready", 32'(chirp_ready), (i == 16) ? 32'd1 : 32'd0);
      check("startup_valid", 32'(phase_valid), 32'd0);
    end
    chirp_init = 1'b0;

    exp_q.push_back(32'd0); exp_q.push_back(32'd100);
    exp_q.push_back(32'd202); exp_q.push_back(32'd306);
    start_chirp(32'd100, 32'd2, 32'd4);
    run_and_check("basic", 4, -1);

    exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h0000_0000);
    start_chirp(32'h8000_0000, 32'd0, 32'd3);
    run_and_check("wrap", 3, -1);

    // Abort after the third valid sample: 0, 5, 11.
    start_chirp(32'd5, 32'd1, 32'd10);
    check("abort_s0", phase_out, 32'd0);
    @(negedge aclk);
    check("abort_s1", phase_out, 32'd5);
    @(negedge aclk);
    check("abort_s2", phase_out, 32'd11);
    check("abort_v2", 32'(phase_valid), 32'd1);
    chirp_enable = 1'b0;
    @(negedge aclk);
    check("abort_valid", 32'(phase_valid), 32'd0);
    check("abort_done", 32'(chirp_done), 32'd0);
    check("abort_ready", 32'(chirp_ready), 32'd1);
    check("abort_hold", phase_out, 32'd11);
    @(negedge aclk);
    check("abort_done2", 32'(chirp_done), 32'd0);
    chirp_enable = 1'b1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd7); exp_q.push_back(32'd17);
    start_chirp(32'd7, 32'd3, 32'd3);
    run_and_check("restart", 3, -1);

    start_chirp(32'd100, 32'd2, 32'd0);
    check("len0_valid", 32'(phase_valid), 32'd0);
    check("len0_state", 32'(state_dbg), 32'd1);
    chirp_enable = 1'b0;
    start_chirp(32'd100, 32'd2, 32'd4);
    check("en_low_valid", 32'(phase_valid), 32'd0);
    check("en_low_ready", 32'(chirp_ready), 32'd1);
    chirp_enable = 1'b1;

    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd3);
    exp_q.push_back(32'd6); exp_q.push_back(32'd10);
    start_chirp(32'd1, 32'd1, 32'd5);
    run_and_check("init_in_run", 5, 1);

    exp_q.push_back(32'd0); exp_q.push_back(32'd10);
    start_chirp(32'd10, 32'd1, 32'd2);
    run_and_check("short", 2, -1);

    start_chirp(32'd1, 32'd0, 32'd10);
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(phase_valid), 32'd0);
    check("mid_rst_phase", phase_out, 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    check("mid_rst_active", 32'(chirp_active), 32'd0);
    @(negedge aclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chirp_sweep_generator.md
Name: chirp_sweep_generator

Overview:
- Linear-FM chirp phase generator. It sits directly downstream of the radar pulse controller.
- Consumes chirp_init and chirp_enable; produces chirp_ready, chirp_active and chirp_done back to the controller.
- Emits one 32-bit phase word per clock to the DAC sine-lookup stage while a chirp runs.
- Start frequency, chirp rate and length are latched per chirp from software-controlled registers.

Parameters:
- PHASE_W, 32, width of the phase and frequency accumulators and of the config words.
- LEN_W, 32, width of the chirp length / sample counter.
- STARTUP_CYCLES, 16, cycles after reset before chirp_ready first asserts (DAC settle).
- GUARD_CYCLES, 8, post-chirp guard interval; used only with CHIRP_GUARD_EN.

Ports:
- aclk  in  1  single clock for all logic (DAC sample clock domain).
- aresetn  in  1  asynchronous active-low reset.
- chirp_init  in  1  single-cycle start request.
- chirp_enable  in  1  level; must be high to start, and to continue, a chirp.
- chirp_len  in  LEN_W  samples per chirp; sampled at start.
- chirp_freq_offset  in  PHASE_W  start phase increment; sampled at start.
- chirp_tuning_word  in  PHASE_W  per-sample increment of the phase increment (chirp rate); sampled at start.
- chirp_ready  out  1  high while a start request is accepted.
- chirp_active  out  1  high while phase samples are emitted.
- chirp_done  out  1  one-cycle pulse after the last sample.
- phase_out  out  PHASE_W  current phase word.
- phase_valid  out  1  phase_out is a chirp sample.

Behaviour:
- All outputs are registered. Reset values:
  - state = STARTUP
  - chirp_ready = 0, chirp_active = 0, chirp_done = 0, phase_valid = 0
  - phase_out = 0, all counters and accumulators = 0
- States:
  - STARTUP: counts STARTUP_CYCLES cycles, then goes to IDLE.
    - chirp_ready asserts on the first IDLE cycle.
    - chirp_init is ignored during STARTUP.
  - IDLE: chirp_ready = 1.
    - On chirp_init & chirp_enable & (chirp_len != 0):
      - latch freq_acc <= chirp_freq_offset, rate <= chirp_tuning_word
      - set phase_acc <= 0, remaining <= chirp_len
      - go to RUN.
    - chirp_init with chirp_len == 0, or with chirp_enable low, is ignored; stay in IDLE.
  - RUN: chirp_active = 1, phase_valid = 1, phase_out = phase_acc. Each cycle:
    - phase_acc <= phase_acc + freq_acc, mod 2^PHASE_W
    - freq_acc <= freq_acc + rate, mod 2^PHASE_W
    - remaining decrements by 1.
    - Sample k (k = 0..len-1) equals k*offset + rate*k*(k-1)/2, mod 2^PHASE_W.
    - The cycle with remaining == 1 is the last sample; then go to DONE.
    - chirp_init during RUN is ignored.
  - DONE: one cycle. chirp_done = 1, chirp_active = 0, phase_valid = 0. Then go to IDLE.
- Latency: init sampled at edge N → phase_valid = 1 with phase_out = 0 after edge N. Exactly chirp_len consecutive valid cycles follow, then chirp_done.
- Abort: chirp_enable low during RUN → next state IDLE, phase_valid = 0, no chirp_done pulse.
- phase_out holds its last value when not valid; downstream must qualify it with phase_valid.
- Wrap-around: both accumulators wrap silently; there is no saturation.
- Asynchronous reset mid-chirp: immediate return to the reset values; STARTUP reruns.

Optional Feature:
- Macro: CHIRP_GUARD_EN.
- Defined:
  - DONE transitions to GUARD, which holds for GUARD_CYCLES cycles with all handshake outputs 0, then goes to IDLE.
  - chirp_init is ignored during GUARD.
  - chirp_enable low during GUARD has no effect.
- Undefined: DONE goes straight to IDLE; GUARD_CYCLES is unused.

Test Plan:
- Reset release, chirp_init held high → chirp_ready rises exactly 16 cycles after reset deassert; no phase_valid before then.
- offset=100, tuning=2, len=4, init pulse → phase_valid for 4 cycles with phase_out 0, 100, 202, 306; chirp_done on the 5th cycle; chirp_ready back next cycle.
- offset=0x8000_0000, tuning=0, len=3 → phase_out 0, 0x8000_0000, 0 (wrap); single chirp_done.
- len=10, chirp_enable dropped after the 3rd valid sample → phase_valid low next cycle, no chirp_done, chirp_ready=1; new init then starts again from phase_out=0.
- len=0 init, and init while RUN (len=5) → first ignored (stays IDLE); second produces no restart, exactly 5 samples.
- CHIRP_GUARD_EN, len=2 → chirp_done, then 8 cycles with chirp_ready=0 and init ignored, then chirp_ready=1.
